// File: rtl/red_pitaya_spi_mst.sv
// rtl/red_pitaya_spi_mst.sv - system-bus SPI master with runtime prescaler, frame length and mode
module red_pitaya_spi_mst #(
    parameter int NCS = 2,
    parameter int DW  = 32,
    parameter int PW  = 8
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    output logic [NCS-1:0]  spi_cs_o,
    output logic            spi_clk_o,
    output logic            spi_mosi_o,
    output logic            spi_mosi_t,
    input  logic            spi_miso_i,
    input  logic [31:0]     sys_addr,
    input  logic [31:0]     sys_wdata,
    input  logic            sys_wen,
    input  logic            sys_ren,
    output logic [31:0]     sys_rdata,
    output logic            sys_err,
    output logic            sys_ack,
    output logic            irq_o
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    localparam logic [5:0] DW6 = 6'(DW);

    state_t          state;
    logic            ctrl_cpol, ctrl_cpha;
    logic [3:0]      ctrl_cs;
    logic [PW-1:0]   cfg_presc;
    logic [5:0]      cfg_len, cfg_wr_len;
    logic [DW-1:0]   tx_reg, rx_reg, sh, rx_sh;
    logic            sts_done, sts_ovr;
    logic            lat_cpol, lat_cpha;
    logic [PW-1:0]   lat_hm1, cnt;
    logic [5:0]      lat_nbits, lat_wr_len, drv_idx;
    logic [6:0]      tog;

    logic            wr_ctrl, wr_cfg, wr_tx, wr_sts, rd_rx, start_req, busy;
    logic [PW-1:0]   hm1_cfg;
    logic [5:0]      nbits_cfg;
    logic [DW-1:0]   tx_aligned;
    logic [NCS-1:0]  cs_mask;
    logic [6:0]      t_next, two_n;
    logic            last_half, toggle_now, drive_ev, sample_ev, xfer_end;
    logic [31:0]     rd_mux;
    logic            unused_bits;

    assign wr_ctrl   = sys_wen && (sys_addr[19:0] == 20'h00000);
    assign wr_cfg    = sys_wen && (sys_addr[19:0] == 20'h00004);
    assign wr_tx     = sys_wen && (sys_addr[19:0] == 20'h00008);
    assign wr_sts    = sys_wen && (sys_addr[19:0] == 20'h00010);
    assign rd_rx     = sys_ren && (sys_addr[19:0] == 20'h0000C);
    assign start_req = wr_ctrl && sys_wdata[0];
    assign busy      = (state != IDLE);
    assign sys_err   = 1'b0;
    assign unused_bits = ^{sys_addr[31:20], sys_wdata};

    // A prescaler of 0 behaves as 1; the counter compares against half-1.
    assign hm1_cfg    = (cfg_presc == '0) ? '0 : cfg_presc - PW'(1);
    assign nbits_cfg  = (cfg_len == 6'd0 || cfg_len > DW6) ? DW6 : cfg_len;
    assign tx_aligned = tx_reg << (DW6 - nbits_cfg);

    assign last_half  = (cnt == lat_hm1);
    assign two_n      = {lat_nbits, 1'b0};
    assign t_next     = tog + 7'd1;
    assign toggle_now = last_half && ((state == SETUP) || (state == SHIFT && tog != two_n));
    // cpha=0 launches on even toggles (none after the final edge), cpha=1 on odd ones.
    assign drive_ev   = lat_cpha ? t_next[0] : (!t_next[0] && t_next != two_n);
    assign sample_ev  = lat_cpha ? !t_next[0] : t_next[0];
    assign xfer_end   = (state == HOLD) && last_half;

    // Chip-select pattern for the index carried by the start write itself.
    always_comb begin
        cs_mask = '0;
        for (int i = 0; i < NCS; i++) begin
            if (sys_wdata[11:8] == 4'(i)) cs_mask[i] = 1'b1;
        end
    end

    // Register read multiplexer; unused bits and unmapped addresses read 0.
    always_comb begin
        rd_mux = '0;
        case (sys_addr[19:0])
            20'h00000: begin
                rd_mux[1]    = ctrl_cpol;
                rd_mux[2]    = ctrl_cpha;
                rd_mux[11:8] = ctrl_cs;
            end
            20'h00004: begin
                rd_mux[PW-1:0]  = cfg_presc;
                rd_mux[21:16]   = cfg_len;
                rd_mux[29:24]   = cfg_wr_len;
            end
            20'h00008: rd_mux[DW-1:0] = tx_reg;
            20'h0000C: rd_mux[DW-1:0] = rx_reg;
            20'h00010: rd_mux[2:0]    = {sts_ovr, sts_done, busy};
            default:   rd_mux = '0;
        endcase
    end

    // Bus-side registers and single-cycle acknowledge; writes while busy only affect the next start.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ctrl_cpol  <= 1'b0;
            ctrl_cpha  <= 1'b0;
            ctrl_cs    <= '0;
            cfg_presc  <= '0;
            cfg_len    <= '0;
            cfg_wr_len <= '0;
            tx_reg     <= '0;
            sys_ack    <= 1'b0;
            sys_rdata  <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_cpol <= sys_wdata[1];
                ctrl_cpha <= sys_wdata[2];
                ctrl_cs   <= sys_wdata[11:8];
            end
            if (wr_cfg) begin
                cfg_presc  <= sys_wdata[PW-1:0];
                cfg_len    <= sys_wdata[21:16];
                cfg_wr_len <= sys_wdata[29:24];
            end
            if (wr_tx) tx_reg <= sys_wdata[DW-1:0];
            sys_ack   <= sys_wen || sys_ren;
            sys_rdata <= sys_ren ? rd_mux : '0;
        end
    end

    // Sticky status: completion beats a same-cycle clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sts_done <= 1'b0;
            sts_ovr  <= 1'b0;
        end else begin
            if (xfer_end)                          sts_done <= 1'b1;
            else if ((wr_sts && sys_wdata[1]) || rd_rx) sts_done <= 1'b0;
            if (start_req && busy)                 sts_ovr <= 1'b1;
            else if (wr_sts && sys_wdata[2])       sts_ovr <= 1'b0;
        end
    end

    // Transfer sequencer: IDLE -> SETUP -> SHIFT -> HOLD, all SPI pins registered.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            spi_cs_o   <= '1;
            spi_clk_o  <= 1'b0;
            spi_mosi_o <= 1'b0;
            spi_mosi_t <= 1'b1;
            irq_o      <= 1'b0;
            rx_reg     <= '0;
            rx_sh      <= '0;
            sh         <= '0;
            lat_cpol   <= 1'b0;
            lat_cpha   <= 1'b0;
            lat_hm1    <= '0;
            lat_nbits  <= '0;
            lat_wr_len <= '0;
            drv_idx    <= '0;
            cnt        <= '0;
            tog        <= '0;
        end else begin
            irq_o <= 1'b0;
            case (state)
                IDLE: begin
                    spi_cs_o   <= '1;
                    spi_clk_o  <= ctrl_cpol;
                    spi_mosi_o <= 1'b0;
                    spi_mosi_t <= 1'b1;
                    if (start_req) begin
                        state      <= SETUP;
                        cnt        <= '0;
                        tog        <= '0;
                        lat_cpol   <= sys_wdata[1];
                        lat_cpha   <= sys_wdata[2];
                        lat_hm1    <= hm1_cfg;
                        lat_nbits  <= nbits_cfg;
                        lat_wr_len <= cfg_wr_len;
                        spi_cs_o   <= ~cs_mask;
                        spi_clk_o  <= sys_wdata[1];
                        rx_sh      <= '0;
                        if (!sys_wdata[2]) begin
                            spi_mosi_o <= tx_aligned[DW-1];
                            spi_mosi_t <= (cfg_wr_len == 6'd0);
                            sh         <= tx_aligned << 1;
                            drv_idx    <= 6'd1;
                        end else begin
                            sh      <= tx_aligned;
                            drv_idx <= 6'd0;
                        end
                    end
                end
                SETUP: begin
                    if (last_half) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                SHIFT: begin
                    if (last_half) begin
                        cnt <= '0;
                        if (tog == two_n) state <= HOLD;
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                HOLD: begin
                    if (last_half) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        spi_cs_o   <= '1;
                        spi_clk_o  <= lat_cpol;
                        spi_mosi_o <= 1'b0;
                        spi_mosi_t <= 1'b1;
                        rx_reg     <= rx_sh;
                        irq_o      <= 1'b1;
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (toggle_now) begin
                spi_clk_o <= ~spi_clk_o;
                tog       <= t_next;
                if (drive_ev) begin
                    spi_mosi_o <= sh[DW-1];
                    spi_mosi_t <= (drv_idx >= lat_wr_len);
                    sh         <= sh << 1;
                    drv_idx    <= drv_idx + 6'd1;
                end
                if (sample_ev) rx_sh <= {rx_sh[DW-2:0], spi_miso_i};
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_spi_mst.sv
// tb/tb_red_pitaya_spi_mst.sv - self-checking bench for red_pitaya_spi_mst
module tb_red_pitaya_spi_mst;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [1:0]  spi_cs_o;
    logic        spi_clk_o, spi_mosi_o, spi_mosi_t, spi_miso_i;
    logic [31:0] sys_addr = '0, sys_wdata = '0, sys_rdata;
    logic        sys_wen = 1'b0, sys_ren = 1'b0, sys_err, sys_ack, irq_o;

    int errs = 0;
    int checks = 0;

    red_pitaya_spi_mst #(.NCS(2), .DW(32), .PW(8)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .spi_cs_o(spi_cs_o), .spi_clk_o(spi_clk_o), .spi_mosi_o(spi_mosi_o),
        .spi_mosi_t(spi_mosi_t), .spi_miso_i(spi_miso_i),
        .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
        .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  presc;
        logic [5:0]  len;
        logic [5:0]  wr;
        logic        cpol;
        logic        cpha;
        logic [3:0]  cs;
        logic [31:0] tx;
        logic [31:0] slave;
        logic [31:0] exp_rx;
        int          exp_cslow;
        int          inject;
        logic [31:0] exp_sts;
    } vec_t;

    // Slave / line monitor state
    logic        cur_cpol = 1'b0, cur_cpha = 1'b0, prev_sclk = 1'b0;
    int          cur_nb = 32;
    logic [31:0] slave_word = '0;
    int          slave_idx = 0;
    int          cs_low0 = 0, cs_low1 = 0, irq_cnt = 0, rise_cnt = 0, tog_seen = 0, mosi_cnt = 0;
    logic [31:0] mosi_word = '0;

    // Slave drives its own bit while MOSI is high-Z, otherwise the line is looped back.
    always_comb begin
        if (!spi_mosi_t) spi_miso_i = spi_mosi_o;
        else if (slave_idx < cur_nb) spi_miso_i = slave_word[cur_nb - 1 - slave_idx];
        else spi_miso_i = 1'b0;
    end

    always @(negedge clk_i) begin
        if (!spi_cs_o[0]) cs_low0 <= cs_low0 + 1;
        if (!spi_cs_o[1]) cs_low1 <= cs_low1 + 1;
        if (irq_o) irq_cnt <= irq_cnt + 1;
        if (spi_clk_o != prev_sclk) begin
            tog_seen <= tog_seen + 1;
            if (spi_clk_o) rise_cnt <= rise_cnt + 1;
            if (cur_cpha ? (spi_clk_o == cur_cpol) : (spi_clk_o != cur_cpol)) begin
                if (!spi_mosi_t) begin
                    mosi_word <= {mosi_word[30:0], spi_mosi_o};
                    mosi_cnt  <= mosi_cnt + 1;
                end
                slave_idx <= slave_idx + 1;
            end
        end
        prev_sclk <= spi_clk_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk_i);
        #1;
        cs_low0 = 0; cs_low1 = 0; irq_cnt = 0; rise_cnt = 0; tog_seen = 0;
        mosi_cnt = 0; mosi_word = '0; slave_idx = 0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        sys_addr = addr; sys_wdata = data; sys_wen = 1'b1;
        @(negedge clk_i);
        sys_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk_i);
        sys_addr = addr; sys_ren = 1'b1;
        @(negedge clk_i);
        sys_ren = 1'b0;
        data = sys_rdata;
        chk("read ack", {31'b0, sys_ack}, 32'h1);
    endtask

    function automatic int eff_n(input logic [5:0] len);
        return (len == 6'd0 || len > 6'd32) ? 32 : int'(len);
    endfunction

    // Reference: bit b of the frame (MSB first) comes from TX while driven, else from the slave.
    function automatic logic [31:0] model_rx(input logic [31:0] tx, input logic [31:0] slave,
                                             input int n, input int wr);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < n; b++) r[n-1-b] = (b < wr) ? tx[n-1-b] : slave[n-1-b];
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int n, half, cyc, m;
        logic [31:0] rd, ctrl_w, txn, exp_mosi;
        logic [63:0] mask;
        n = eff_n(v.len);
        half = (v.presc == 0) ? 1 : int'(v.presc);
        m = (int'(v.wr) < n) ? int'(v.wr) : n;
        mask = (64'd1 << n) - 64'd1;
        txn = v.tx & mask[31:0];
        exp_mosi = (m == 0) ? 32'h0 : (txn >> (n - m));
        ctrl_w = {20'h0, v.cs, 5'h0, v.cpha, v.cpol, 1'b0};
        bus_write(32'h04, {2'b0, v.wr, 2'b0, v.len, 8'h0, v.presc});
        bus_write(32'h08, v.tx);
        bus_write(32'h00, ctrl_w);
        cur_cpol = v.cpol; cur_cpha = v.cpha; cur_nb = n; slave_word = v.slave;
        repeat (2) @(negedge clk_i);
        clear_mon();
        bus_write(32'h00, ctrl_w | 32'h1);
        cyc = 0;
        while (irq_cnt == 0 && cyc < 2000) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == v.inject) begin
                sys_addr = 32'h0; sys_wdata = 32'h105; sys_wen = 1'b1;
            end else begin
                sys_wen = 1'b0;
            end
        end
        sys_wen = 1'b0;
        chk({tag, " done within budget"}, {31'b0, cyc < 2000}, 32'h1);
        repeat (3) @(negedge clk_i);
        chk({tag, " cs0 low cycles"}, cs_low0, (v.cs == 0) ? v.exp_cslow : 0);
        chk({tag, " cs1 low cycles"}, cs_low1, (v.cs == 1) ? v.exp_cslow : 0);
        chk({tag, " sclk rising edges"}, rise_cnt, n);
        chk({tag, " irq pulses"}, irq_cnt, 1);
        chk({tag, " mosi bits driven"}, mosi_cnt, m);
        chk({tag, " mosi data"}, mosi_word, exp_mosi);
        chk({tag, " sclk idle"}, {31'b0, spi_clk_o}, {31'b0, v.cpol});
        bus_read(32'h10, rd);
        chk({tag, " sts"}, rd, v.exp_sts);
        bus_read(32'h0C, rd);
        chk({tag, " rx"}, rd, v.exp_rx);
        bus_read(32'h10, rd);
        chk({tag, " sts after rx read"}, rd, v.exp_sts & 32'h4);
        bus_read(32'h00, rd);
        chk({tag, " ctrl readback"}, rd, (v.inject != 0) ? 32'h104 : ctrl_w);
        bus_write(32'h10, 32'h6);
        bus_read(32'h10, rd);
        chk({tag, " sts cleared"}, rd, 32'h0);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        logic [31:0] rd;
        int cyc;

        //          presc len  wr  cpol cpha cs  tx            slave         exp_rx        cslow inj sts
        tbl[0] = '{8'd2, 6'd16, 6'd16, 1'b0, 1'b0, 4'd0, 32'h0000A55A, 32'h0, 32'h0000A55A, 68, 0, 32'h2};
        tbl[1] = '{8'd1, 6'd16, 6'd8,  1'b0, 1'b0, 4'd0, 32'h00009100, 32'h3C, 32'h0000913C, 34, 0, 32'h2};
        tbl[2] = '{8'd0, 6'd0,  6'd32, 1'b1, 1'b1, 4'd1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 66, 0, 32'h2};
        tbl[3] = '{8'd1, 6'd8,  6'd8,  1'b1, 1'b0, 4'd3, 32'h0000005A, 32'h0, 32'h0000005A, 0,  0, 32'h2};
        tbl[4] = '{8'd3, 6'd12, 6'd0,  1'b0, 1'b1, 4'd0, 32'h00000FFF, 32'hABC, 32'h00000ABC, 78, 0, 32'h2};
        tbl[5] = '{8'd2, 6'd16, 6'd16, 1'b0, 1'b0, 4'd0, 32'h00001234, 32'h0, 32'h00001234, 68, 20, 32'h6};

        repeat (3) @(negedge clk_i);
        chk("reset cs", {30'b0, spi_cs_o}, 32'h3);
        chk("reset sclk", {31'b0, spi_clk_o}, 32'h0);
        chk("reset mosi_t", {31'b0, spi_mosi_t}, 32'h1);
        chk("reset irq", {31'b0, irq_o}, 32'h0);
        chk("reset ack", {31'b0, sys_ack}, 32'h0);
        rstn_i = 1'b1;
        for (int a = 0; a <= 5; a++) begin
            bus_read(32'(a * 4), rd);
            chk($sformatf("reset read 0x%02h", a * 4), rd, 32'h0);
        end
        chk("sys_err", {31'b0, sys_err}, 32'h0);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a frame.
        bus_write(32'h04, {2'b0, 6'd16, 2'b0, 6'd16, 8'h0, 8'd2});
        bus_write(32'h08, 32'h0000FFFF);
        bus_write(32'h00, 32'h0);
        cur_cpol = 1'b0; cur_cpha = 1'b0; cur_nb = 16; slave_word = '0;
        clear_mon();
        bus_write(32'h00, 32'h1);
        cyc = 0;
        while (tog_seen != 9 && cyc < 500) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("mid reset reached toggle 9", {31'b0, cyc < 500}, 32'h1);
        chk("mid reset sclk high", {31'b0, spi_clk_o}, 32'h1);
        #2 rstn_i = 1'b0;
        #1;
        chk("async reset cs", {30'b0, spi_cs_o}, 32'h3);
        chk("async reset sclk", {31'b0, spi_clk_o}, 32'h0);
        chk("async reset mosi_t", {31'b0, spi_mosi_t}, 32'h1);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("no irq after reset", irq_cnt, 0);
        bus_read(32'h0C, rd);
        chk("rx after reset", rd, 32'h0);
        bus_read(32'h10, rd);
        chk("sts after reset", rd, 32'h0);

        for (int i = 0; i < 8; i++) begin
            v.presc = 8'($urandom_range(0, 3));
            v.len   = 6'($urandom_range(0, 40));
            v.wr    = 6'($urandom_range(0, 40));
            v.cpol  = 1'($urandom_range(0, 1));
            v.cpha  = 1'($urandom_range(0, 1));
            v.cs    = 4'($urandom_range(0, 3));
            v.tx    = $urandom;
            v.slave = $urandom;
            v.exp_rx = model_rx(v.tx, v.slave, eff_n(v.len), int'(v.wr));
            v.exp_cslow = (2 * eff_n(v.len) + 2) * ((v.presc == 0) ? 1 : int'(v.presc));
            v.inject = 0;
            v.exp_sts = 32'h2;
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
